// File: rtl/frame_buffer_ex_pkg.sv
// frame_buffer_ex_pkg
//   Shared definitions for the frame-buffer readback checker: FSM state
//   encoding, the default frame length, counter widths and the LFSR step.
package frame_buffer_ex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // 320x240 frame
    localparam int FRAME_LEN_DEFAULT = 76800;

    localparam int IDX_W = 17;
    localparam int ERR_W = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Galois LFSR, polynomial x^8+x^4+x^3+x^2+1: 0x20 -> 0x40 -> 0x80 -> 0x1D
    localparam logic [7:0] LFSR_TAPS = 8'h1D;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/frame_buffer_ex_checker_if.sv
// frame_buffer_ex_checker_if
//   Pixel readback stream into the checker.
//   in_data  : pixel read back from the frame buffer
//   in_valid : in_data is valid (source -> checker)
//   in_ready : checker accepts a pixel this cycle (checker -> source)
interface frame_buffer_ex_checker_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/frame_buffer_ex_lfsr8.sv
// frame_buffer_ex_lfsr8
//   8-bit Galois LFSR used as the expected-pixel generator.
//   clk, reset_n : clock, async active-low reset (register -> SEED)
//   enable       : 0 forces the register back to SEED
//   load, ldata  : synchronous parallel load (when enabled)
//   pause        : hold the current value (when enabled, not loading)
//   lfsr_out     : current register value
module frame_buffer_ex_lfsr8
    import frame_buffer_ex_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       load,
    input  logic       pause,
    input  logic [7:0] ldata,
    output logic [7:0] lfsr_out
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (!enable)
            lfsr_d = SEED;
        else if (load)
            lfsr_d = ldata;
        else if (!pause)
            lfsr_d = lfsr8_next(lfsr_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lfsr_q <= SEED;
        else
            lfsr_q <= lfsr_d;
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/frame_buffer_ex_checker.sv
// frame_buffer_ex_checker
//   Checks a frame read back from the frame buffer against an LFSR pattern
//   starting at SEED. Counts mismatches (saturating) and records the first one.
//   clk, reset_n  : clock, async active-low reset
//   start         : run request, honoured in IDLE or DONE
//   abort         : ends a run at once; a pixel offered in that cycle is dropped
//   pix (slave)   : in_data / in_valid / in_ready pixel stream
//   busy, done    : in RUN / in DONE
//   pass          : DONE with no mismatches
//   err_count     : mismatch count, saturates at 0xFFFF
//   first_err_*   : index, expected and received value of the first mismatch
module frame_buffer_ex_checker
    import frame_buffer_ex_pkg::*;
#(
    parameter int unsigned SEED      = 32,
    parameter int          FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       abort,
    frame_buffer_ex_checker_if.slave   pix,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_count,
    output logic [IDX_W-1:0]           first_err_idx,
    output logic [7:0]                 first_err_exp,
    output logic [7:0]                 first_err_got
);

    localparam logic [7:0]       SEED8    = 8'(SEED);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0] fe_idx_q, fe_idx_d;
    logic [7:0]       fe_exp_q, fe_exp_d;
    logic [7:0]       fe_got_q, fe_got_d;

    logic       in_run;
    logic       accept;
    logic       mismatch;
    logic [7:0] exp_px;

    assign in_run       = (state_q == ST_RUN);
    assign pix.in_ready = in_run;
    // abort wins over a pixel offered in the same cycle
    assign accept       = in_run && pix.in_valid && !abort;
    assign mismatch     = accept && (pix.in_data != exp_px);

    // Outside RUN the generator sits at SEED, so every run starts fresh;
    // in RUN it steps once per accepted pixel.
    frame_buffer_ex_lfsr8 #(
        .SEED (SEED8)
    ) u_lfsr (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (in_run),
        .load     (1'b0),
        .pause    (!accept),
        .ldata    (8'h00),
        .lfsr_out (exp_px)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        fe_idx_d  = fe_idx_q;
        fe_exp_d  = fe_exp_q;
        fe_got_d  = fe_got_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    idx_d     = '0;
                    err_cnt_d = '0;
                    fe_idx_d  = '0;
                    fe_exp_d  = '0;
                    fe_got_d  = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (mismatch) begin
                        if (err_cnt_q != ERR_MAX)
                            err_cnt_d = err_cnt_q + 1'b1;
                        // count is cleared at start and never returns to zero,
                        // so zero means no mismatch seen yet in this run
                        if (err_cnt_q == '0) begin
                            fe_idx_d = idx_q;
                            fe_exp_d = exp_px;
                            fe_got_d = pix.in_data;
                        end
                    end
                    if (idx_q == LAST_IDX)
                        state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            err_cnt_q <= '0;
            fe_idx_q  <= '0;
            fe_exp_q  <= '0;
            fe_got_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
            fe_idx_q  <= fe_idx_d;
            fe_exp_q  <= fe_exp_d;
            fe_got_q  <= fe_got_d;
        end
    end

    assign busy          = in_run;
    assign done          = (state_q == ST_DONE);
    assign pass          = done && (err_cnt_q == '0);
    assign err_count     = err_cnt_q;
    assign first_err_idx = fe_idx_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_got = fe_got_q;

endmodule

// File: tb/tb_frame_buffer_ex_checker.sv
// Bench for frame_buffer_ex_checker: four instances with FRAME_LEN 4, 8,
// 70000 and 1, each checked every cycle against a transaction-level model.
module tb_frame_buffer_ex_checker;

    localparam int NDUT = 4;
    localparam logic [7:0] SEED8 = 8'h20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  d_a [NDUT];
    logic        v_a [NDUT];
    logic        s_a [NDUT];
    logic        ab_a[NDUT];
    logic        rdy_a [NDUT];
    logic        busy_a[NDUT];
    logic        done_a[NDUT];
    logic        pass_a[NDUT];
    logic [15:0] err_a [NDUT];
    logic [16:0] fidx_a[NDUT];
    logic [7:0]  fexp_a[NDUT];
    logic [7:0]  fgot_a[NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        localparam int L = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 70000 : 1;
        frame_buffer_ex_checker_if pif ();
        assign pif.in_data  = d_a[g];
        assign pif.in_valid = v_a[g];
        assign rdy_a[g]     = pif.in_ready;
        frame_buffer_ex_checker #(.SEED(32), .FRAME_LEN(L)) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .start         (s_a[g]),
            .abort         (ab_a[g]),
            .pix           (pif.slave),
            .busy          (busy_a[g]),
            .done          (done_a[g]),
            .pass          (pass_a[g]),
            .err_count     (err_a[g]),
            .first_err_idx (fidx_a[g]),
            .first_err_exp (fexp_a[g]),
            .first_err_got (fgot_a[g])
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          flen [NDUT] = '{4, 8, 70000, 1};
    bit          m_run [NDUT];
    bit          m_done[NDUT];
    int          m_idx [NDUT];
    int          m_err [NDUT];
    logic [16:0] m_fidx[NDUT];
    logic [7:0]  m_fexp[NDUT];
    logic [7:0]  m_fgot[NDUT];
    logic [7:0]  m_exp [NDUT];   // expected pixel m_idx: SEED * x^m_idx in GF(2^8)

    // multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] gf_mulx(logic [7:0] b);
        logic [8:0] w;
        w = {b, 1'b0};
        if (w[8]) w = w ^ 9'h11D;
        return w[7:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_run[k] = 0; m_done[k] = 0; m_idx[k] = 0; m_err[k] = 0;
            m_fidx[k] = '0; m_fexp[k] = '0; m_fgot[k] = '0; m_exp[k] = SEED8;
        end
    endtask

    task automatic model_edge(int k, bit v, logic [7:0] d, bit s, bit a);
        if (!m_run[k]) begin
            if (s) begin
                m_run[k] = 1; m_done[k] = 0; m_idx[k] = 0; m_err[k] = 0;
                m_fidx[k] = '0; m_fexp[k] = '0; m_fgot[k] = '0; m_exp[k] = SEED8;
            end
        end else if (a) begin
            m_run[k] = 0;
        end else if (v) begin
            if (d != m_exp[k]) begin
                if (m_err[k] == 0) begin
                    m_fidx[k] = 17'(m_idx[k]); m_fexp[k] = m_exp[k]; m_fgot[k] = d;
                end
                if (m_err[k] < 65535) m_err[k]++;
            end
            m_idx[k]++;
            m_exp[k] = gf_mulx(m_exp[k]);
            if (m_idx[k] == flen[k]) begin
                m_run[k] = 0; m_done[k] = 1;
            end
        end
    endtask

    task automatic cmp_all(int k);
        chk($sformatf("u%0d.busy", k),  32'(busy_a[k]), 32'(m_run[k]));
        chk($sformatf("u%0d.ready", k), 32'(rdy_a[k]),  32'(m_run[k]));
        chk($sformatf("u%0d.done", k),  32'(done_a[k]), 32'(m_done[k]));
        chk($sformatf("u%0d.pass", k),  32'(pass_a[k]), 32'(m_done[k] && m_err[k] == 0));
        chk($sformatf("u%0d.err", k),   32'(err_a[k]),  32'(m_err[k]));
        chk($sformatf("u%0d.fidx", k),  32'(fidx_a[k]), 32'(m_fidx[k]));
        chk($sformatf("u%0d.fexp", k),  32'(fexp_a[k]), 32'(m_fexp[k]));
        chk($sformatf("u%0d.fgot", k),  32'(fgot_a[k]), 32'(m_fgot[k]));
    endtask

    // One clock on instance k; called 1 time unit after a rising edge.
    task automatic cyc(int k, bit v, logic [7:0] d, bit s, bit a);
        d_a[k] = d; v_a[k] = v; s_a[k] = s; ab_a[k] = a;
        @(posedge clk);
        model_edge(k, v, d, s, a);
        #1;
        d_a[k] = '0; v_a[k] = 0; s_a[k] = 0; ab_a[k] = 0;
        cmp_all(k);
    endtask

    task automatic good(int k);
        cyc(k, 1'b1, m_exp[k], 1'b0, 1'b0);
    endtask

    logic [7:0] ref4[4] = '{8'h20, 8'h40, 8'h80, 8'h1D};

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            d_a[k] = '0; v_a[k] = 0; s_a[k] = 0; ab_a[k] = 0;
        end
        model_reset();
        #3;
        for (int k = 0; k < NDUT; k++) cmp_all(k);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NDUT; k++) cmp_all(k);

        // correct 4-pixel frame with literal values
        cyc(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, ref4[i], 0, 0);
        chk("f4_ok.done", 32'(done_a[0]), 1);
        chk("f4_ok.pass", 32'(pass_a[0]), 1);
        chk("f4_ok.err",  32'(err_a[0]),  0);

        // third pixel corrupted
        cyc(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, (i == 2) ? 8'h81 : ref4[i], 0, 0);
        chk("f4_bad.done", 32'(done_a[0]), 1);
        chk("f4_bad.pass", 32'(pass_a[0]), 0);
        chk("f4_bad.err",  32'(err_a[0]),  1);
        chk("f4_bad.fidx", 32'(fidx_a[0]), 2);
        chk("f4_bad.fexp", 32'(fexp_a[0]), 32'h80);
        chk("f4_bad.fgot", 32'(fgot_a[0]), 32'h81);

        // correct stream with gaps
        cyc(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 8'hFF, 0, 0);
            cyc(0, 0, 8'h00, 0, 0);
            cyc(0, 1, ref4[i], 0, 0);
        end
        chk("f4_gap.pass", 32'(pass_a[0]), 1);
        chk("f4_gap.err",  32'(err_a[0]),  0);

        // abort with the 3rd valid pixel (which is wrong, and must not count)
        cyc(1, 0, 8'h00, 1, 0);
        cyc(1, 1, 8'h20, 0, 0);
        cyc(1, 1, 8'h11, 0, 0);
        cyc(1, 1, 8'h00, 0, 1);
        chk("abort.busy", 32'(busy_a[1]), 0);
        chk("abort.done", 32'(done_a[1]), 0);
        chk("abort.err",  32'(err_a[1]),  1);
        cyc(1, 0, 8'h00, 1, 0);
        cyc(1, 1, 8'h20, 0, 0);
        chk("restart.err", 32'(err_a[1]), 0);
        for (int i = 1; i < 8; i++) good(1);
        chk("restart.pass", 32'(pass_a[1]), 1);

        // single-pixel frame
        cyc(3, 0, 8'h00, 1, 0);
        cyc(3, 1, 8'h20, 0, 0);
        chk("len1.done", 32'(done_a[3]), 1);
        chk("len1.pass", 32'(pass_a[3]), 1);

        // long all-zero frame: count saturates
        cyc(2, 0, 8'h00, 1, 0);
        for (int i = 0; i < 70000 && m_run[2]; i++) cyc(2, 1, 8'h00, 0, 0);
        chk("sat.done", 32'(done_a[2]), 1);
        chk("sat.err",  32'(err_a[2]),  32'hFFFF);
        chk("sat.fidx", 32'(fidx_a[2]), 0);
        chk("sat.fexp", 32'(fexp_a[2]), 32'h20);
        chk("sat.fgot", 32'(fgot_a[2]), 0);

        // reset mid-run
        cyc(1, 0, 8'h00, 1, 0);
        cyc(1, 1, 8'h00, 0, 0);
        cyc(1, 1, 8'h40, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < NDUT; k++) cmp_all(k);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        cmp_all(1);
        cyc(1, 0, 8'h00, 1, 0);
        for (int i = 0; i < 8; i++) good(1);
        chk("post_rst.pass", 32'(pass_a[1]), 1);

        // randomized runs on the short instances
        for (int r = 0; r < 40; r++) begin
            int k;
            int budget;
            k = (r % 3 == 2) ? 3 : (r % 3);
            cyc(k, 0, 8'h00, 1, 0);
            budget = 0;
            while (m_run[k] && budget < 200) begin
                bit v, a, s, bad;
                logic [7:0] d;
                v   = ($urandom_range(0, 3) != 0);
                a   = ($urandom_range(0, 39) == 0);
                s   = ($urandom_range(0, 9) == 0);
                bad = ($urandom_range(0, 5) == 0);
                d   = bad ? 8'($urandom) : m_exp[k];
                cyc(k, v, d, s, a);
                budget++;
            end
            chk($sformatf("rnd%0d.ended", r), 32'(m_run[k]), 0);
            if (r % 5 == 0) cyc(k, $urandom_range(0, 1) == 1, 8'($urandom), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buffer_ex_checker.md
FRAME_BUFFER_EX_CHECKER -- requirements
Module: frame_buffer_ex_checker

Interface
REQ-001 SHALL have parameter SEED, default 32, the LFSR seed; the first expected pixel is SEED[7:0].
REQ-002 SHALL have parameter FRAME_LEN, default 76800, the number of pixels checked per run; legal range 1..2^17-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle run request, honoured only in IDLE or DONE.
REQ-006 SHALL have port abort, input, 1 bit: terminates a run immediately.
REQ-007 SHALL have port in_data, input, 8 bits: pixel read back from the frame buffer.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the checker accepts a pixel this cycle.
REQ-010 SHALL have port busy, output, 1 bit: high in RUN.
REQ-011 SHALL have port done, output, 1 bit: high in DONE.
REQ-012 SHALL have port pass, output, 1 bit: high in DONE when err_count==0.
REQ-013 SHALL have port err_count, output, 16 bits: mismatch count, saturating.
REQ-014 SHALL have port first_err_idx, output, 17 bits: pixel index of the first mismatch.
REQ-015 SHALL have ports first_err_exp and first_err_got, output, 8 bits each: expected and received values at the first mismatch.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 State transitions SHALL be: IDLE/DONE -> RUN on start; RUN -> DONE on accepting pixel FRAME_LEN-1; RUN -> IDLE on abort.
REQ-018 start SHALL be ignored in RUN.
REQ-019 abort SHALL take priority over accepting a pixel in the same cycle; that pixel is not counted.
REQ-020 in_ready SHALL equal 1 exactly in RUN (combinational from state).
REQ-021 A pixel SHALL be accepted when in_valid && in_ready.
REQ-022 On accept, in_data SHALL be compared with the current LFSR output.
REQ-023 On a mismatch, err_count SHALL increment at the next edge and saturate at 0xFFFF.
REQ-024 On the first mismatch of a run, first_err_idx, first_err_exp and first_err_got SHALL be captured; later mismatches SHALL NOT overwrite them.
REQ-025 The LFSR SHALL hold SEED while not in RUN (enable=0).
REQ-026 In RUN the LFSR SHALL have enable=1, load=0 and pause=!accept, so it advances exactly one step per accepted pixel.
REQ-027 The expected sequence from seed 0x20 SHALL be 0x20, 0x40, 0x80, 0x1D, ...
REQ-028 The pixel index SHALL be a 17-bit counter, cleared on start and incremented on accept.
REQ-029 The pixel index SHALL NOT wrap within a run, because the run ends at FRAME_LEN-1.
REQ-030 On the RUN -> IDLE/DONE edge, err_count SHALL already include the last accepted pixel; there is no additional latency.
REQ-031 err_count and the first-error fields SHALL clear to 0 when start is honoured.
REQ-032 err_count and the first-error fields SHALL be held through DONE and after abort.
REQ-033 With FRAME_LEN=1, the first accept SHALL go directly to DONE.
REQ-034 Stalls (in_valid=0) SHALL hold all state unchanged.

Reset
REQ-035 reset_n low SHALL asynchronously force state IDLE, pixel index 0, and the LFSR to SEED.
REQ-036 reset_n low SHALL force err_count, first_err_idx, first_err_exp and first_err_got to 0.
REQ-037 reset_n low SHALL force in_ready, busy, done and pass to 0.
REQ-038 Reset asserted mid-run SHALL discard the run; no done pulse is produced.

Structure
REQ-039 The state encoding and the default FRAME_LEN constant SHALL live in a shared package, frame_buffer_ex_pkg.
REQ-040 The expected-data generator SHALL be one instance of the existing 8-bit LFSR block, frame_buffer_ex_lfsr8, with seed=SEED and ldata tied to 0.
REQ-041 The remaining logic (FSM, counters, capture registers) SHALL be flat in this module.

Verification
REQ-042 FRAME_LEN=4, start, feed 0x20, 0x40, 0x80, 0x1D with in_valid=1 -> in_ready for 4 cycles, then done=1, pass=1, err_count=0.
REQ-043 Same, but the third pixel is 0x81 -> done=1, pass=0, err_count=1, first_err_idx=2, first_err_exp=0x80, first_err_got=0x81.
REQ-044 Same correct stream with in_valid=0 gaps between pixels -> identical result to REQ-042; the LFSR does not advance on gaps.
REQ-045 FRAME_LEN=8, abort asserted together with the 3rd valid pixel -> next state IDLE, done=0, err_count unchanged; the next start re-expects 0x20.
REQ-046 FRAME_LEN=70000, all pixels 0x00 -> err_count saturates at 0xFFFF, first_err_idx=0, first_err_exp=0x20.
REQ-047 reset_n pulsed low mid-run -> all outputs 0 immediately; after release, start plus the correct stream passes.
